// File: rtl/maxpool2x2_stage_if.sv
// ============================================================================
// maxpool2x2_stage_if : control handshake and RAM buses of the 2x2 max-pool stage
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface maxpool2x2_stage_if #(
  parameter int ADDR_W  = 4,
  parameter int OADDR_W = 2,
  parameter int DATA_W  = 8
);
  logic               start;
  logic               busy;
  logic               done;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic               wr_en;
  logic [OADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]  wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

`default_nettype wire

// File: rtl/maxpool2x2_stage.sv
// ============================================================================
// maxpool2x2_stage : 2x2 stride-2 max pooling from a sync-read map RAM into a
//                    pooled-map RAM, one window per 6 cycles, sticky done.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool2x2_stage #(
  parameter int IN_W   = 26,
  parameter int IN_H   = 26,
  parameter int DATA_W = 8,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  maxpool2x2_stage_if.master    bus_if
);

  localparam int OUT_W   = IN_W / 2;
  localparam int OUT_H   = IN_H / 2;
  localparam int ADDR_W  = (IN_W * IN_H > 1) ? $clog2(IN_W * IN_H) : 1;
  localparam int OADDR_W = (OUT_W * OUT_H > 1) ? $clog2(OUT_W * OUT_H) : 1;
  localparam int I_W     = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int J_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  if (IN_W < 2 || IN_H < 2) begin : g_bad_dims
    $error("maxpool2x2_stage: IN_W and IN_H must both be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_RD2  = 3'd3,
    S_RD3  = 3'd4,
    S_ACC  = 3'd5,
    S_WR   = 3'd6,
    S_FIN  = 3'd7
  } state_t;

  state_t              state_q;
  logic [I_W-1:0]      i_q;
  logic [J_W-1:0]      j_q;
  logic [DATA_W-1:0]   max_q;
  logic                busy_q;
  logic                done_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                wr_en_q;
  logic [OADDR_W-1:0]  wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;

  logic [I_W-1:0]      i_d;
  logic [J_W-1:0]      j_d;
  logic                last_win;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W-1:0]   next_base_addr;
  logic [OADDR_W-1:0]  out_addr;
  logic                gt;
  logic [DATA_W-1:0]   max_d;

  always_comb begin
    i_d      = i_q;
    j_d      = j_q + 1'b1;
    last_win = 1'b0;
    if (int'(j_q) == OUT_W - 1) begin
      j_d = '0;
      i_d = i_q + 1'b1;
      if (int'(i_q) == OUT_H - 1) begin
        last_win = 1'b1;
        i_d      = '0;
      end
    end
    base_addr      = ADDR_W'(2 * int'(i_q) * IN_W + 2 * int'(j_q));
    next_base_addr = ADDR_W'(2 * int'(i_d) * IN_W + 2 * int'(j_d));
    out_addr       = OADDR_W'(int'(i_q) * OUT_W + int'(j_q));
    if (SIGNED != 0) begin
      gt = $signed(bus_if.rd_data) > $signed(max_q);
    end else begin
      gt = bus_if.rd_data > max_q;
    end
    // Strict compare: a tie keeps the current max.
    max_d = gt ? bus_if.rd_data : max_q;
  end

  // Outputs are registered alongside the state, so each is set on entry to its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      max_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (bus_if.start) begin
            state_q   <= S_RD0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        S_RD0: begin
          state_q   <= S_RD1;
          rd_addr_q <= base_addr + ADDR_W'(1);
        end
        S_RD1: begin
          state_q   <= S_RD2;
          max_q     <= bus_if.rd_data;
          rd_addr_q <= base_addr + ADDR_W'(IN_W);
        end
        S_RD2: begin
          state_q   <= S_RD3;
          max_q     <= max_d;
          rd_addr_q <= base_addr + ADDR_W'(IN_W + 1);
        end
        S_RD3: begin
          state_q <= S_ACC;
          max_q   <= max_d;
          rd_en_q <= 1'b0;
        end
        S_ACC: begin
          state_q   <= S_WR;
          max_q     <= max_d;
          wr_en_q   <= 1'b1;
          wr_addr_q <= out_addr;
          wr_data_q <= max_d;
        end
        S_WR: begin
          wr_en_q <= 1'b0;
          i_q     <= i_d;
          j_q     <= j_d;
          if (last_win) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_RD0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= next_base_addr;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_if.busy    = busy_q;
  assign bus_if.done    = done_q;
  assign bus_if.rd_en   = rd_en_q;
  assign bus_if.rd_addr = rd_addr_q;
  assign bus_if.wr_en   = wr_en_q;
  assign bus_if.wr_addr = wr_addr_q;
  assign bus_if.wr_data = wr_data_q;

endmodule

`default_nettype wire
